// File: rtl/regbank_write_arbiter_pkg.sv
// rtl/regbank_write_arbiter_pkg.sv - shared state encodings, width defaults and pointer helper
package regbank_write_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 16;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// rtl/regbank_write_arbiter_if.sv - requester-side and Regbank write-port bundle
interface regbank_write_arbiter_if
  import regbank_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) ();

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    lock;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    gnt;
  logic                  err;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;

  modport master (
    output req, lock, req_addr, req_data,
    input  gnt, err, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req, lock, req_addr, req_data,
    output gnt, err, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/regbank_write_arbiter_rr_pick.sv
// rtl/regbank_write_arbiter_rr_pick.sv - combinational rotate-priority picker
module regbank_write_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          found
);

  always_comb begin
    int pos;
    pos    = 0;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos] && !mask[pos]) begin
        found       = 1'b1;
        idx         = PW'(pos);
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - round-robin owner of the Regbank write port with bounded burst lock
module regbank_write_arbiter
  import regbank_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int LOCK_MAX   = 4,
  parameter int PROTECT_R0 = 1
) (
  input logic                  clk,
  input logic                  rst,
  regbank_write_arbiter_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [1:0]         state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      owner;
  logic [CW-1:0]      lock_cnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic               err_q;
  logic               wr_en_q;
  logic [AW-1:0]      wr_addr_q;
  logic [DW-1:0]      wr_data_q;

  logic [NUM_REQ-1:0] pick_oh;
  logic [PW-1:0]      pick_idx;
  logic               pick_found;
  logic               keep;
  logic               win;
  logic [PW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic               protect;

  // The current grant holder is always masked; only a continuing lock bypasses the picker.
  regbank_write_arbiter_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req    (bus.req),
    .mask   (gnt_q),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign keep     = (state == ST_LOCK) && bus.req[owner] && bus.lock[owner]
                    && (lock_cnt < CW'(LOCK_MAX));
  assign win      = keep || pick_found;
  assign win_idx  = keep ? owner : pick_idx;
  assign win_oh   = keep ? (NUM_REQ'(1) << owner) : pick_oh;
  assign sel_addr = bus.req_addr[win_idx*AW +: AW];
  assign sel_data = bus.req_data[win_idx*DW +: DW];
  assign protect  = (PROTECT_R0 != 0) && (sel_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      lock_cnt  <= '0;
      gnt_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (win) begin
      gnt_q     <= win_oh;
      wr_addr_q <= sel_addr;
      wr_data_q <= sel_data;
      wr_en_q   <= !protect;
      err_q     <= protect;
      owner     <= win_idx;
      rr_ptr    <= PW'(wrap_inc(int'(win_idx), NUM_REQ));
      if (keep) begin
        lock_cnt <= lock_cnt + CW'(1);
      end else if (bus.lock[pick_idx]) begin
        state    <= ST_LOCK;
        lock_cnt <= CW'(1);
      end else begin
        state    <= ST_GRANT;
        lock_cnt <= '0;
      end
    end else begin
      state    <= ST_IDLE;
      lock_cnt <= '0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
      wr_en_q  <= 1'b0;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.err     = err_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb/tb_regbank_write_arbiter.sv - directed vector bench with a shadow Regbank
module tb_regbank_write_arbiter;
  import regbank_write_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 16;

  localparam logic [11:0] A  = {4'd7, 4'd3, 4'd5};
  localparam logic [47:0] D  = {16'h2222, 16'h1111, 16'h00AA};
  localparam logic [11:0] AP = {4'd0, 4'd3, 4'd5};
  localparam logic [47:0] DP = {16'hFFFF, 16'h1111, 16'h00AA};

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [11:0] addr;
    logic [47:0] data;
    logic [2:0]  gnt;
    logic        wr_en;
    logic        err;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regbank_write_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

  regbank_write_arbiter #(
    .NUM_REQ(N), .AW(AW), .DW(DW), .LOCK_MAX(4), .PROTECT_R0(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] regbank [16];
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] lk,
                              input logic [11:0] a, input logic [47:0] d, input logic [2:0] g,
                              input logic we, input logic er, input logic [3:0] wa,
                              input logic [15:0] wd);
    vec_t v;
    v.rst = r; v.req = rq; v.lock = lk; v.addr = a; v.data = d;
    v.gnt = g; v.wr_en = we; v.err = er; v.wr_addr = wa; v.wr_data = wd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one cycle of inputs; the shadow Regbank takes the write presented before the edge.
  task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] lk,
                      input logic [11:0] a, input logic [47:0] d);
    logic we;
    logic [3:0] wa;
    logic [15:0] wd;
    we = bus.wr_en; wa = bus.wr_addr; wd = bus.wr_data;
    rst = r; bus.req = rq; bus.lock = lk; bus.req_addr = a; bus.req_data = d;
    @(posedge clk);
    if (we === 1'b1) regbank[wa] = wd;
    #1;
    check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    check("wr_en_one_gnt", 32'(!bus.wr_en || $onehot(bus.gnt)), 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [2:0] g, input logic we,
                            input logic er, input logic [3:0] wa, input logic [15:0] wd);
    check({tag, " gnt"}, 32'(bus.gnt), 32'(g));
    check({tag, " wr_en"}, 32'(bus.wr_en), 32'(we));
    check({tag, " err"}, 32'(bus.err), 32'(er));
    check({tag, " wr_addr"}, 32'(bus.wr_addr), 32'(wa));
    check({tag, " wr_data"}, 32'(bus.wr_data), 32'(wd));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regbank[i] = 16'h1000 + 16'(i);
    bus.req = '0; bus.lock = '0; bus.req_addr = '0; bus.req_data = '0;

    vecs.push_back(mk(1, 3'b111, 3'b000, A, D, 3'b000, 0, 0, 4'd0, 16'h0000));
    vecs.push_back(mk(1, 3'b111, 3'b000, A, D, 3'b000, 0, 0, 4'd0, 16'h0000));
    vecs.push_back(mk(0, 3'b001, 3'b000, A, D, 3'b001, 1, 0, 4'd5, 16'h00AA));
    vecs.push_back(mk(0, 3'b001, 3'b000, A, D, 3'b000, 0, 0, 4'd5, 16'h00AA));
    vecs.push_back(mk(0, 3'b000, 3'b000, A, D, 3'b000, 0, 0, 4'd5, 16'h00AA));
    vecs.push_back(mk(1, 3'b000, 3'b000, A, D, 3'b000, 0, 0, 4'd0, 16'h0000));
    vecs.push_back(mk(0, 3'b111, 3'b000, A, D, 3'b001, 1, 0, 4'd5, 16'h00AA));
    vecs.push_back(mk(0, 3'b111, 3'b000, A, D, 3'b010, 1, 0, 4'd3, 16'h1111));
    vecs.push_back(mk(0, 3'b110, 3'b000, A, D, 3'b100, 1, 0, 4'd7, 16'h2222));
    vecs.push_back(mk(0, 3'b100, 3'b000, A, D, 3'b000, 0, 0, 4'd7, 16'h2222));
    vecs.push_back(mk(0, 3'b111, 3'b000, A, D, 3'b001, 1, 0, 4'd5, 16'h00AA));
    vecs.push_back(mk(0, 3'b111, 3'b000, A, D, 3'b010, 1, 0, 4'd3, 16'h1111));
    vecs.push_back(mk(0, 3'b000, 3'b000, A, D, 3'b000, 0, 0, 4'd3, 16'h1111));
    vecs.push_back(mk(0, 3'b100, 3'b000, AP, DP, 3'b100, 0, 1, 4'd0, 16'hFFFF));
    vecs.push_back(mk(0, 3'b000, 3'b000, AP, DP, 3'b000, 0, 0, 4'd0, 16'hFFFF));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].addr, vecs[i].data);
      expect_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].wr_en, vecs[i].err,
                 vecs[i].wr_addr, vecs[i].wr_data);
    end

    check("regbank r5", 32'(regbank[5]), 32'h00AA);
    check("regbank r3", 32'(regbank[3]), 32'h1111);
    check("regbank r7", 32'(regbank[7]), 32'h2222);
    check("regbank r0 protected", 32'(regbank[0]), 32'h1000);

    // Lock burst capped at four writes, competitor served once, owner relocks.
    step(1, 3'b000, 3'b000, A, D);
    expect_out("lock rst", 3'b000, 0, 0, 4'd0, 16'h0000);
    step(0, 3'b010, 3'b010, A, D);
    expect_out("lock w1", 3'b010, 1, 0, 4'd3, 16'h1111);
    for (int i = 2; i <= 4; i++) begin
      step(0, 3'b011, 3'b010, A, D);
      expect_out($sformatf("lock w%0d", i), 3'b010, 1, 0, 4'd3, 16'h1111);
    end
    step(0, 3'b011, 3'b010, A, D);
    expect_out("lock release", 3'b001, 1, 0, 4'd5, 16'h00AA);
    step(0, 3'b011, 3'b010, A, D);
    expect_out("lock resume", 3'b010, 1, 0, 4'd3, 16'h1111);
    step(0, 3'b000, 3'b000, A, D);
    expect_out("lock idle", 3'b000, 0, 0, 4'd3, 16'h1111);

    // Reset during the second locked write.
    step(1, 3'b000, 3'b000, A, D);
    expect_out("mid rst0", 3'b000, 0, 0, 4'd0, 16'h0000);
    step(0, 3'b010, 3'b010, A, D);
    expect_out("mid w1", 3'b010, 1, 0, 4'd3, 16'h1111);
    step(0, 3'b010, 3'b010, A, D);
    expect_out("mid w2", 3'b010, 1, 0, 4'd3, 16'h1111);
    step(1, 3'b010, 3'b010, A, D);
    expect_out("mid rst", 3'b000, 0, 0, 4'd0, 16'h0000);
    step(0, 3'b110, 3'b000, A, D);
    expect_out("mid after", 3'b010, 1, 0, 4'd3, 16'h1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
